// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES key schedule.
//   state_t / ST_*   : key-schedule FSM encoding (2 bits)
//   SHIFT1_SCHED     : bit (k-1) set when round k rotates C/D by one place
//   PC1_TAB, PC2_TAB : standard DES permutation tables, 1-based DES bit numbers
//   pc1_perm()       : 64-bit key -> 56-bit C0||D0
// DES numbers bits from the MSB, so DES bit b of an N-bit vector is v[N-b].
package des_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_GEN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
  localparam logic [15:0] SHIFT1_SCHED = 16'h8103;

  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // PC1 never selects a parity bit, so every entry is at most 63 and the
  // source index 64-b fits in 6 bits when written as (63-b)+1.
  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] r;
    r = 56'd0;
    for (logic [5:0] j = 6'd0; j < 6'd56; j = j + 6'd1) begin
      r[6'd55 - j] = key[6'd63 - PC1_TAB[j] + 6'd1];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// des_pc2_perm: combinational DES PC-2 permutation (56 -> 48 bits).
//   cd_i : C||D, DES bit 1 at cd_i[55]
//   k_o  : 48-bit subkey, DES bit 1 at k_o[47]
module des_pc2_perm (
  input  logic [55:0] cd_i,
  output logic [47:0] k_o
);
  import des_pkg::*;

  // Table-driven bit select; DES bit b of C||D lives at cd_i[56-b].
  always_comb begin
    k_o = 48'd0;
    for (logic [5:0] j = 6'd0; j < 6'd48; j = j + 6'd1) begin
      k_o[6'd47 - j] = cd_i[6'd56 - PC2_TAB[j]];
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: DES key-schedule responder.
//   clk, reset (async, active-low)
//   key[63:0]     raw key incl. parity, DES bit 1 = MSB
//   iPd / fPd     parity-drop request level / C0,D0 loaded flag (sticky)
//   iKg / fKg     key-generation request level / all subkeys valid (sticky)
//   busy          high while the 16 generation steps run
//   decrypt,round select the subkey; subkey is registered, one-clock latency
module des_key_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key,
  input  logic        iPd,
  input  logic        iKg,
  input  logic        decrypt,
  input  logic [4:0]  round,
  output logic        fPd,
  output logic        fKg,
  output logic        busy,
  output logic [47:0] subkey
);
  import des_pkg::*;

  state_t      state_q, state_d;
  logic [27:0] creg_q, creg_d;
  logic [27:0] dreg_q, dreg_d;
  logic [4:0]  k_q, k_d;
  logic        fpd_q, fpd_d;
  logic        fkg_q, fkg_d;
  logic        busy_q, busy_d;
  logic [47:0] subkey_q, subkey_d;
  logic [47:0] store_q [16];

  logic [3:0]  k_idx_s;
  logic        rot1_s;
  logic [27:0] c_rot_s, d_rot_s;
  logic [47:0] pc2_s;
  logic        store_we_s;
  logic        round_ok_s;
  logic [3:0]  rd_idx_s;

  // Step k (1..16) maps to store slot and schedule bit k-1.
  assign k_idx_s = 4'(k_q - 5'd1);
  assign rot1_s  = SHIFT1_SCHED[k_idx_s];
  assign c_rot_s = rot1_s ? {creg_q[26:0], creg_q[27]} : {creg_q[25:0], creg_q[27:26]};
  assign d_rot_s = rot1_s ? {dreg_q[26:0], dreg_q[27]} : {dreg_q[25:0], dreg_q[27:26]};

  des_pc2_perm u_pc2 (
    .cd_i (({c_rot_s, d_rot_s})),
    .k_o  (pc2_s)
  );

  // Control FSM next-state, C/D and flag updates.
  always_comb begin
    state_d    = state_q;
    creg_d     = creg_q;
    dreg_d     = dreg_q;
    k_d        = k_q;
    fpd_d      = fpd_q;
    fkg_d      = fkg_q;
    store_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iPd) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        {creg_d, dreg_d} = pc1_perm(key);
        fpd_d   = 1'b1;
        fkg_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_GEN: begin
        // GEN runs to completion regardless of the request inputs.
        creg_d     = c_rot_s;
        dreg_d     = d_rot_s;
        store_we_s = 1'b1;
        if (k_q == 5'd16) begin
          fkg_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      ST_DONE: begin
        // fKg gates both requests so held levels fire only once.
        if (iKg && !fkg_q) begin
          k_d     = 5'd1;
          state_d = ST_GEN;
        end else if (iPd && fkg_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_GEN);
  end

  // Read port: range check on round first, then index 17-round or round.
  always_comb begin
    round_ok_s = (round >= 5'd1) && (round <= 5'd16);
    if (decrypt) begin
      rd_idx_s = 4'(5'd16 - round);
    end else begin
      rd_idx_s = 4'(round - 5'd1);
    end
    if (round_ok_s) begin
      subkey_d = store_q[rd_idx_s];
    end else begin
      subkey_d = 48'd0;
    end
  end

  // Control, key halves, flags and read-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      creg_q   <= 28'd0;
      dreg_q   <= 28'd0;
      k_q      <= 5'd0;
      fpd_q    <= 1'b0;
      fkg_q    <= 1'b0;
      busy_q   <= 1'b0;
      subkey_q <= 48'd0;
    end else begin
      state_q  <= state_d;
      creg_q   <= creg_d;
      dreg_q   <= dreg_d;
      k_q      <= k_d;
      fpd_q    <= fpd_d;
      fkg_q    <= fkg_d;
      busy_q   <= busy_d;
      subkey_q <= subkey_d;
    end
  end

  // Subkey store, one slot written per generation step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        store_q[i] <= 48'd0;
      end
    end else begin
      if (store_we_s) begin
        store_q[k_idx_s] <= pc2_s;
      end
    end
  end

  assign fPd    = fpd_q;
  assign fKg    = fkg_q;
  assign busy   = busy_q;
  assign subkey = subkey_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: a reference model computes each
// subkey directly from C0||D0 via the cumulative rotation count, and tracks
// the request/flag protocol per cycle; outputs are compared every cycle.
module tb_des_key_sched;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] key;
  logic        iPd, iKg, decrypt;
  logic [4:0]  round;
  logic        fPd, fKg, busy;
  logic [47:0] subkey;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  localparam int M_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int M_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk     (clk),
    .reset   (reset),
    .key     (key),
    .iPd     (iPd),
    .iKg     (iKg),
    .decrypt (decrypt),
    .round   (round),
    .fPd     (fPd),
    .fKg     (fKg),
    .busy    (busy),
    .subkey  (subkey)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [55:0] m_pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 1; i <= 56; i++) r[56-i] = k[64-M_PC1[i-1]];
    return r;
  endfunction

  // Subkey n from scratch: total rotation = sum of per-round shifts.
  function automatic logic [47:0] m_subkey(input logic [55:0] cd0, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] r;
    int sh = 0;
    for (int i = 1; i <= n; i++) sh += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    c = cd0[55:28];
    d = cd0[27:0];
    for (int s = 0; s < sh; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 1; i <= 48; i++) r[48-i] = cd[56-M_PC2[i-1]];
    return r;
  endfunction

  // Protocol model.
  logic        m_fpd, m_fkg, m_loading, m_started, m_skv;
  int          m_step;
  logic [55:0] m_cd0;
  logic [47:0] m_store [1:16];
  logic [47:0] m_sk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fpd <= 1'b0; m_fkg <= 1'b0; m_loading <= 1'b0; m_started <= 1'b0;
      m_skv <= 1'b0; m_step <= 0; m_cd0 <= '0; m_sk <= '0;
      for (int i = 1; i <= 16; i++) m_store[i] <= '0;
    end else begin
      if (m_step != 0) begin
        m_store[m_step] <= m_subkey(m_cd0, m_step);
        if (m_step == 16) begin
          m_step <= 0;
          m_fkg  <= 1'b1;
        end else begin
          m_step <= m_step + 1;
        end
      end else if (m_loading) begin
        m_cd0 <= m_pc1(key); m_fpd <= 1'b1; m_fkg <= 1'b0; m_loading <= 1'b0;
      end else if (!m_started) begin
        if (iPd) begin m_loading <= 1'b1; m_started <= 1'b1; end
      end else if (iKg && !m_fkg) begin
        m_step <= 1;
      end else if (iPd && m_fkg) begin
        m_loading <= 1'b1;
      end
      if (round >= 1 && round <= 16) begin
        m_sk  <= m_store[decrypt ? 17 - int'(round) : int'(round)];
        m_skv <= m_fkg;
      end else begin
        m_sk  <= '0;
        m_skv <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("fPd", fPd, m_fpd);
    chk("fKg", fKg, m_fkg);
    chk("busy", busy, m_step != 0);
    if (!reset || m_skv) chk("subkey", subkey, m_sk);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load();
    iPd = 1'b1; step();
    iPd = 1'b0; step();
  endtask

  // iKg raised, then up to 40 cycles observed; busy must last 16 cycles and
  // fKg must appear in the 17th cycle after the sampling edge.
  task automatic gen_watch(input string name, input bit drop);
    int bcnt = 0;
    int fat  = 0;
    iKg = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (busy) bcnt++;
      if (fKg && fat == 0) fat = j;
      if (j == 3 && drop) iKg = 1'b0;
      if (j == 4 && drop) iPd = 1'b1;
      if (j == 6 && drop) iPd = 1'b0;
    end
    chk({name, "_busy_cycles"}, 64'(bcnt), 64'd16);
    chk({name, "_fkg_cycle"}, 64'(fat), 64'd17);
  endtask

  task automatic rd(input logic [4:0] r, input logic d, input logic [47:0] exp, input string name);
    round = r; decrypt = d; step();
    chk(name, subkey, exp);
  endtask

  initial begin
    int loads;
    int bcnt;
    reset = 1'b0; key = KEY1; iPd = 1'b0; iKg = 1'b0; decrypt = 1'b0; round = 5'd1;

    chk("pin_pc1", m_pc1(KEY1), 64'hF0CCAAF556678F);
    chk("pin_k1", m_subkey(m_pc1(KEY1), 1), K1);
    chk("pin_k16", m_subkey(m_pc1(KEY1), 16), K16);
    chk("pin_zero", m_subkey(m_pc1(64'd0), 1), 48'd0);

    repeat (3) step();
    chk("rst_subkey", subkey, 48'd0);
    reset = 1'b1; step();

    iPd = 1'b1; step();
    iPd = 1'b0;
    chk("fpd_early", fPd, 1'b0);
    step();
    chk("fpd_two_cycles", fPd, 1'b1);
    chk("c0", dut.creg_q, 28'hF0CCAAF);
    chk("d0", dut.dreg_q, 28'h556678F);

    gen_watch("gen1", 1'b1);
    rd(5'd1, 1'b0, K1, "enc_r1");
    rd(5'd16, 1'b0, K16, "enc_r16");
    rd(5'd1, 1'b1, K16, "dec_r1");
    rd(5'd16, 1'b1, K1, "dec_r16");
    rd(5'd0, 1'b0, 48'd0, "r0_enc");
    rd(5'd0, 1'b1, 48'd0, "r0_dec");
    rd(5'd17, 1'b0, 48'd0, "r17_enc");
    rd(5'd17, 1'b1, 48'd0, "r17_dec");
    rd(5'd31, 1'b1, 48'd0, "r31_dec");
    for (int r = 0; r < 18; r++) begin
      round = 5'(r); decrypt = r[0]; step();
    end

    // Reset in the middle of generation.
    round = 5'd1; decrypt = 1'b0;
    do_load();
    chk("rekey_fkg_clear", fKg, 1'b0);
    iKg = 1'b1;
    repeat (8) step();
    chk("gen_step8_busy", busy, 1'b1);
    reset = 1'b0; iKg = 1'b0;
    #2;
    chk("mid_rst_fpd", fPd, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    step();
    chk("mid_rst_state", dut.state_q, ST_IDLE);
    chk("mid_rst_fkg", fKg, 1'b0);
    chk("mid_rst_subkey", subkey, 48'd0);
    chk("mid_rst_c", dut.creg_q, 28'd0);
    chk("mid_rst_k", dut.k_q, 5'd0);
    reset = 1'b1; step();
    do_load();
    gen_watch("gen2", 1'b0);
    iKg = 1'b0;
    rd(5'd1, 1'b0, K1, "again_r1");
    rd(5'd16, 1'b0, K16, "again_r16");

    // Rekey with iPd held: exactly one LOAD.
    key = 64'd0; iPd = 1'b1; loads = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (dut.state_q == ST_LOAD) loads++;
    end
    chk("rekey_loads", 64'(loads), 64'd1);
    chk("rekey_fkg", fKg, 1'b0);
    iPd = 1'b0;
    gen_watch("gen3", 1'b0);
    bcnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (busy) bcnt++;
    end
    chk("held_ikg_no_restart", 64'(bcnt), 64'd0);
    iKg = 1'b0;
    rd(5'd1, 1'b0, 48'd0, "zero_r1");
    rd(5'd16, 1'b1, 48'd0, "zero_dec_r16");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
